// File: rtl/toggle_pkg.sv
// toggle_pkg: definitions shared by the toggle-handshake receiver and transmitter.
//   toggle_state_e          - handshake FSM states (StIdle, StHold)
//   TOGGLE_SYNC_STAGES_DEF  - default synchroniser depth on the incoming toggle
//   TOGGLE_CNT_W_DEF        - default width of the transfer counter
package toggle_pkg;

    localparam int unsigned TOGGLE_SYNC_STAGES_DEF = 2;
    localparam int unsigned TOGGLE_CNT_W_DEF       = 16;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StHold = 1'b1
    } toggle_state_e;

endpackage

// File: rtl/toggle_rx_if.sv
// toggle_rx_if: handshake bundle around the toggle receiver.
//   req_tog  - request toggle from the sender (one event per transition)
//   data_in  - sender data, stable until ack_tog changes
//   ack_tog  - acknowledge toggle back to the sender
//   valid    - data_out holds an unconsumed word
//   ready    - consumer accepts when valid && ready
//   data_out - captured word
// Modports: slave = receiver, master = sender/consumer environment.
interface toggle_rx_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req_tog;
    logic [WIDTH-1:0] data_in;
    logic             ack_tog;
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data_out;

    modport master (
        output req_tog,
        output data_in,
        output ready,
        input  ack_tog,
        input  valid,
        input  data_out
    );

    modport slave (
        input  req_tog,
        input  data_in,
        input  ready,
        output ack_tog,
        output valid,
        output data_out
    );
endinterface

// File: rtl/toggle_sync.sv
// toggle_sync: SYNC_STAGES-deep flop chain for a single asynchronous level.
//   i_clk   - rising-edge clock
//   i_rst_n - asynchronous active-low reset, chain clears to 0
//   i_d     - asynchronous input level
//   o_q     - synchronised level (last flop of the chain)
// SYNC_STAGES must be at least 2.
module toggle_sync
    import toggle_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = TOGGLE_SYNC_STAGES_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_rx.sv
// toggle_rx: receive end of a two-phase toggle handshake.
// Each transition of bus.req_tog is synchronised, the sender word is captured
// and offered on a valid/ready port; every accepted word flips bus.ack_tog and
// increments the transfer counter.
//   i_clk       - rising-edge clock
//   i_rst_n     - asynchronous active-low reset
//   bus         - toggle_rx_if.slave (req_tog, data_in, ready in; ack_tog, valid, data_out out)
//   o_evt_count - accepted-word count, wraps modulo 2^CNT_W
//   o_overrun   - sticky flag: new request seen while a word was still held
// Optional feature macro: TOGGLE_RX_OVERRUN_EN builds the overrun detector;
// without it o_overrun is tied to 0.
module toggle_rx
    import toggle_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = TOGGLE_SYNC_STAGES_DEF,
    parameter int unsigned CNT_W       = TOGGLE_CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    toggle_rx_if.slave       bus,
    output logic [CNT_W-1:0] o_evt_count,
    output logic             o_overrun
);

    logic             w_req_sync;
    logic             w_event;

    toggle_state_e    r_state;
    logic             r_req_seen;
    logic             r_valid;
    logic             r_ack_tog;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_evt_count;

    toggle_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_d    (bus.req_tog),
        .o_q    (w_req_sync)
    );

    // A new word is pending whenever the synchronised level differs from the
    // last level consumed; a level comparison means a request arriving while
    // a word is held simply waits and is picked up in the next StIdle cycle.
    assign w_event = (w_req_sync != r_req_seen);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_req_seen  <= 1'b0;
            r_valid     <= 1'b0;
            r_ack_tog   <= 1'b0;
            r_data      <= '0;
            r_evt_count <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_event) begin
                        r_data     <= bus.data_in;
                        r_req_seen <= w_req_sync;
                        r_valid    <= 1'b1;
                        r_state    <= StHold;
                    end
                end
                StHold: begin
                    if (r_valid && bus.ready) begin
                        r_valid     <= 1'b0;
                        r_ack_tog   <= ~r_ack_tog;
                        r_evt_count <= r_evt_count + 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef TOGGLE_RX_OVERRUN_EN
    logic r_overrun;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overrun <= 1'b0;
        end else if (r_state == StHold && w_event) begin
            r_overrun <= 1'b1;
        end
    end

    assign o_overrun = r_overrun;
`else
    assign o_overrun = 1'b0;
`endif

    assign bus.ack_tog  = r_ack_tog;
    assign bus.valid    = r_valid;
    assign bus.data_out = r_data;
    assign o_evt_count  = r_evt_count;

endmodule

// File: tb/tb_toggle_rx.sv
module tb_toggle_rx;

    logic       clk;
    logic       rst_n;
    logic [15:0] evt_count;
    logic       overrun;
    logic [3:0] wrap_count;
    logic       wrap_overrun;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef TOGGLE_RX_OVERRUN_EN
    logic exp_ovr = 1'b1;
`else
    logic exp_ovr = 1'b0;
`endif

    toggle_rx_if #(.WIDTH(8)) m_if ();
    toggle_rx_if #(.WIDTH(8)) w_if ();

    toggle_rx u_dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .bus        (m_if.slave),
        .o_evt_count(evt_count),
        .o_overrun  (overrun)
    );

    toggle_rx #(
        .CNT_W(4)
    ) u_wrap (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .bus        (w_if.slave),
        .o_evt_count(wrap_count),
        .o_overrun  (wrap_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        m_if.req_tog   = 1'b0;
        m_if.data_in   = 8'h00;
        m_if.ready     = 1'b0;
        w_if.req_tog   = 1'b0;
        w_if.data_in   = 8'h00;
        w_if.ready     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        m_if.req_tog = 1'b1;
        m_if.data_in = 8'hFF;
        m_if.ready   = 1'b0;
        w_if.req_tog = 1'b0;
        w_if.data_in = 8'h00;
        w_if.ready   = 1'b0;
        repeat (3) tick();
        n_cmp++; if (m_if.valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", m_if.valid); end
        n_cmp++; if (m_if.data_out !== 8'h00) begin n_fail++; $display("FAIL rst_data got %h exp 00", m_if.data_out); end
        n_cmp++; if (m_if.ack_tog !== 1'b0) begin n_fail++; $display("FAIL rst_ack got %b exp 0", m_if.ack_tog); end
        n_cmp++; if (evt_count !== 16'd0) begin n_fail++; $display("FAIL rst_cnt got %0d exp 0", evt_count); end
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_ovr got %b exp 0", overrun); end
        rst_n = 1'b1;
        tick();
        tick();
        n_cmp++; if (m_if.valid !== 1'b0) begin n_fail++; $display("FAIL rst_early_valid got %b exp 0", m_if.valid); end
        tick();
        n_cmp++; if (m_if.valid !== 1'b1) begin n_fail++; $display("FAIL rst_rel_valid got %b exp 1", m_if.valid); end
        n_cmp++; if (m_if.data_out !== 8'hFF) begin n_fail++; $display("FAIL rst_rel_data got %h exp ff", m_if.data_out); end
        // Reset while a word is held discards it immediately.
        rst_n = 1'b0;
        #2;
        n_cmp++; if (m_if.valid !== 1'b0 || m_if.data_out !== 8'h00) begin
            n_fail++; $display("FAIL rst_mid got valid %b data %h exp 0 00", m_if.valid, m_if.data_out);
        end
    endtask

    task automatic test_single();
        do_reset();
        m_if.ready   = 1'b1;
        m_if.data_in = 8'hA5;
        m_if.req_tog = ~m_if.req_tog;
        tick();
        tick();
        n_cmp++; if (m_if.valid !== 1'b0) begin n_fail++; $display("FAIL single_early got %b exp 0", m_if.valid); end
        tick();
        n_cmp++; if (m_if.valid !== 1'b1 || m_if.data_out !== 8'hA5) begin
            n_fail++; $display("FAIL single_cap got valid %b data %h exp 1 a5", m_if.valid, m_if.data_out);
        end
        tick();
        n_cmp++; if (m_if.valid !== 1'b0) begin n_fail++; $display("FAIL single_drop got %b exp 0", m_if.valid); end
        n_cmp++; if (m_if.ack_tog !== 1'b1) begin n_fail++; $display("FAIL single_ack got %b exp 1", m_if.ack_tog); end
        n_cmp++; if (evt_count !== 16'd1) begin n_fail++; $display("FAIL single_cnt got %0d exp 1", evt_count); end
        n_cmp++; if (m_if.data_out !== 8'hA5) begin n_fail++; $display("FAIL single_hold got %h exp a5", m_if.data_out); end
    endtask

    task automatic test_backpressure();
        m_if.ready   = 1'b0;
        m_if.data_in = 8'h3C;
        m_if.req_tog = ~m_if.req_tog;
        repeat (3) tick();
        n_cmp++; if (m_if.valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got %b exp 1", m_if.valid); end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (m_if.valid !== 1'b1 || m_if.data_out !== 8'h3C || m_if.ack_tog !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got valid %b data %h ack %b exp 1 3c 1",
                         i, m_if.valid, m_if.data_out, m_if.ack_tog);
            end
        end
        m_if.ready = 1'b1;
        tick();
        n_cmp++; if (m_if.valid !== 1'b0) begin n_fail++; $display("FAIL bp_drop got %b exp 0", m_if.valid); end
        n_cmp++; if (m_if.ack_tog !== 1'b0) begin n_fail++; $display("FAIL bp_ack got %b exp 0", m_if.ack_tog); end
        n_cmp++; if (evt_count !== 16'd2) begin n_fail++; $display("FAIL bp_cnt got %0d exp 2", evt_count); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got[$];
        logic       tx_tog;
        logic       last_ack;
        bit         seen;
        do_reset();
        m_if.ready = 1'b1;
        tx_tog     = 1'b0;
        for (int w = 1; w <= 5; w++) begin
            m_if.data_in = 8'(w);
            tx_tog       = ~tx_tog;
            m_if.req_tog = tx_tog;
            last_ack     = m_if.ack_tog;
            seen         = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                tick();
                if (m_if.valid === 1'b1) got.push_back(m_if.data_out);
                if (m_if.ack_tog !== last_ack) seen = 1'b1;
            end
            n_cmp++; if (!seen) begin n_fail++; $display("FAIL b2b_timeout word %0d got no ack exp ack", w); end
        end
        n_cmp++; if (got.size() != 5) begin n_fail++; $display("FAIL b2b_len got %0d exp 5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== 8'(i + 1)) begin
                n_fail++; $display("FAIL b2b_word[%0d] got %h exp %h", i, got[i], 8'(i + 1));
            end
        end
        n_cmp++; if (evt_count !== 16'd5) begin n_fail++; $display("FAIL b2b_cnt got %0d exp 5", evt_count); end
        n_cmp++; if (m_if.ack_tog !== 1'b1) begin n_fail++; $display("FAIL b2b_ack got %b exp 1", m_if.ack_tog); end
    endtask

    task automatic test_wrap();
        logic last_ack;
        bit   seen;
        do_reset();
        w_if.ready = 1'b1;
        for (int w = 1; w <= 17; w++) begin
            w_if.data_in = 8'(w);
            w_if.req_tog = ~w_if.req_tog;
            last_ack     = w_if.ack_tog;
            seen         = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                tick();
                if (w_if.ack_tog !== last_ack) seen = 1'b1;
            end
            n_cmp++; if (!seen) begin n_fail++; $display("FAIL wrap_timeout word %0d got no ack exp ack", w); end
            if (w == 16) begin
                n_cmp++; if (wrap_count !== 4'd0) begin n_fail++; $display("FAIL wrap_16 got %0d exp 0", wrap_count); end
            end
        end
        n_cmp++; if (wrap_count !== 4'd1) begin n_fail++; $display("FAIL wrap_17 got %0d exp 1", wrap_count); end
        n_cmp++; if (w_if.ack_tog !== 1'b1) begin n_fail++; $display("FAIL wrap_ack got %b exp 1", w_if.ack_tog); end
    endtask

    task automatic test_overrun();
        do_reset();
        m_if.ready   = 1'b0;
        m_if.data_in = 8'h11;
        m_if.req_tog = ~m_if.req_tog;
        repeat (3) tick();
        n_cmp++; if (m_if.valid !== 1'b1 || m_if.data_out !== 8'h11) begin
            n_fail++; $display("FAIL ovr_first got valid %b data %h exp 1 11", m_if.valid, m_if.data_out);
        end
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_pre got %b exp 0", overrun); end
        m_if.data_in = 8'h22;
        m_if.req_tog = ~m_if.req_tog;
        repeat (4) tick();
        n_cmp++; if (overrun !== exp_ovr) begin n_fail++; $display("FAIL ovr_flag got %b exp %b", overrun, exp_ovr); end
        n_cmp++; if (m_if.valid !== 1'b1 || m_if.data_out !== 8'h11) begin
            n_fail++; $display("FAIL ovr_held got valid %b data %h exp 1 11", m_if.valid, m_if.data_out);
        end
        m_if.ready = 1'b1;
        tick();
        n_cmp++; if (m_if.valid !== 1'b0 || m_if.ack_tog !== 1'b1) begin
            n_fail++; $display("FAIL ovr_acc1 got valid %b ack %b exp 0 1", m_if.valid, m_if.ack_tog);
        end
        tick();
        n_cmp++; if (m_if.valid !== 1'b1 || m_if.data_out !== 8'h22) begin
            n_fail++; $display("FAIL ovr_second got valid %b data %h exp 1 22", m_if.valid, m_if.data_out);
        end
        tick();
        n_cmp++; if (m_if.ack_tog !== 1'b0 || evt_count !== 16'd2) begin
            n_fail++; $display("FAIL ovr_acc2 got ack %b cnt %0d exp 0 2", m_if.ack_tog, evt_count);
        end
        n_cmp++; if (overrun !== exp_ovr) begin n_fail++; $display("FAIL ovr_sticky got %b exp %b", overrun, exp_ovr); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_wrap();
        test_overrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/toggle_rx.md
# toggle_rx

Receive end of the two-phase toggle handshake: the sending side signals each new word by flipping a T-flip-flop-driven request line, and this block recovers those flips into discrete events. Each event is synchronised, captured, and presented on a valid/ready port. It also returns an acknowledge toggle and counts completed transfers. It sits at the boundary between an unrelated source domain and local logic.

## Interface
- WIDTH, 8, data word width
- SYNC_STAGES, 2, synchroniser depth on req_tog (minimum 2)
- CNT_W, 16, width of the event counter

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_tog  in  1  request toggle from the sender; each transition is one event
- data_in  in  WIDTH  sender data; held stable by the sender until ack_tog changes
- ack_tog  out  1  acknowledge toggle; flips once per accepted word
- valid  out  1  data_out holds an unconsumed word
- ready  in  1  consumer accepts when valid && ready
- data_out  out  WIDTH  captured word
- evt_count  out  CNT_W  number of accepted words, wraps modulo 2^CNT_W
- overrun  out  1  sticky error flag (see Configuration)

## Operation
- Reset value (reset low): all outputs 0; synchroniser flops 0; req_seen 0; state IDLE.
- req_tog passes through SYNC_STAGES flops to produce req_sync. req_seen holds the last level consumed.
- An event exists when req_sync != req_seen.
- State IDLE, on an event:
  - data_out <= data_in
  - req_seen <= req_sync
  - valid <= 1
  - go to HOLD
- State HOLD, on valid && ready:
  - valid <= 0
  - ack_tog <= ~ack_tog
  - evt_count <= evt_count + 1
  - go to IDLE
- data_out holds its value after acceptance until the next capture.
- ready is ignored in IDLE.
- An event that is pending at the moment of acceptance is captured in the first IDLE cycle after it, so no event is lost.
- Two transitions of req_tog between samples cancel and cannot be detected. This is a sender protocol violation.
- evt_count wraps from all-ones to 0 without any flag.
- Reset asserted mid-transfer clears everything immediately:
  - any held word is discarded
  - ack_tog returns to 0
  - the sender must also be reset

## Timing
- req_tog edge to valid high: SYNC_STAGES + 1 rising clock edges. With the default, valid rises on the 3rd rising edge after the transition.
- Acceptance edge: valid low, ack_tog flipped and evt_count incremented, all on the same edge.
- Minimum spacing between accepted words, in IDLE with ready held high: 2 cycles (capture edge, accept edge).
- ack_tog is a registered output with no combinational path from any input.
- valid, data_out and overrun are registered.

## Configuration
- TOGGLE_RX_OVERRUN_EN defined:
  - In HOLD, an event (req_sync != req_seen) detected before acceptance sets overrun to 1.
  - overrun stays 1 until reset.
  - The pending event is still captured normally after acceptance.
- TOGGLE_RX_OVERRUN_EN undefined:
  - overrun is tied to 0 and no detection logic is built.
  - All other behaviour is identical.

## Structure
- Shared package toggle_pkg holds:
  - the state enum (IDLE, HOLD)
  - default constants TOGGLE_SYNC_STAGES_DEF = 2 and TOGGLE_CNT_W_DEF = 16
- The same package is reused by the matching toggle transmitter.
- One sub-module: toggle_sync, a parameterised SYNC_STAGES-deep flop chain with asynchronous active-low reset to 0.
- The FSM, capture register and counter stay in toggle_rx.

## Test plan
- Reset: hold reset low, drive req_tog = 1 and data_in = 8'hFF → all outputs 0. Release reset → valid rises 3 edges later with data_out = 8'hFF (the level 1 differs from req_seen 0).
- Single transfer: req_tog 0→1, data_in = 8'hA5, ready = 1 → valid high for exactly 1 cycle, data_out = 8'hA5, ack_tog = 1, evt_count = 1.
- Backpressure: ready = 0 for 10 cycles after valid → valid and data_out = 8'h3C held, ack_tog unchanged. Raise ready → ack_tog flips on that edge and valid drops.
- Back-to-back: sender (modelled with a T flip-flop) sends 8'h01..8'h05, each sent after it sees ack → 5 outputs in order, evt_count = 5, final ack_tog = 1.
- Wrap: CNT_W = 4, send 17 words → evt_count = 1.
- Overrun (macro defined): toggle req_tog again while in HOLD with ready = 0 → overrun = 1. After ready, the second word is delivered and overrun stays 1. With the macro undefined, overrun stays 0 for the same stimulus.
